uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PRESC_W, default 6, width of the prescale input.
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx_in  in  1  serial line, already synchronised to clk, idle high.
REQ-006 SHALL have port prescale  in  PRESC_W  oversampling ratio; legal values 8, 16, 32.
REQ-007 SHALL have port par_en  in  1  parity bit present.
REQ-008 SHALL have port par_typ  in  1  0 = even, 1 = odd parity.
REQ-009 SHALL have port stp2_en  in  1  two stop bits expected.
REQ-010 SHALL have port p_data  out  DATA_W  received word, LSB first on the line.
REQ-011 SHALL have port data_valid  out  1  one-cycle pulse, p_data valid.
REQ-012 SHALL have port par_err  out  1  one-cycle pulse, parity mismatch.
REQ-013 SHALL have port stp_err  out  1  one-cycle pulse, stop bit sampled low.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, ERR_CHK, DATA_VLD.
REQ-016 IDLE -> START when rx_in = 0; prescale, par_en, par_typ and stp2_en are latched on that cycle, and changes mid-frame are ignored.
REQ-017 edge_cnt SHALL count 0..prescale-1 per bit; bit_cnt SHALL increment when edge_cnt = prescale-1; both clear on entering START.
REQ-018 Each bit value SHALL be the 2-of-3 majority of rx_in at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1, registered at edge_cnt = prescale/2+2.
REQ-019 START: at the end of the bit, a sampled 1 (glitch) -> IDLE with no outputs; a sampled 0 -> DATA.
REQ-020 DATA: sampled bits shift into the deserialiser LSB first; after DATA_W bits -> PARITY if par_en, else STOP.
REQ-021 PARITY: at the end of the bit, the computed parity (XOR of data, inverted if par_typ) is compared with the sampled bit -> STOP.
REQ-022 STOP: each stop bit is checked at its sample point; after the last stop bit (1 or 2) is sampled -> ERR_CHK, without waiting for the end of the bit.
REQ-023 ERR_CHK (1 cycle): no error -> DATA_VLD; error -> IDLE, with par_err/stp_err pulsed next cycle.
REQ-024 DATA_VLD (1 cycle): p_data is updated and data_valid pulses; then -> START if rx_in = 0, else IDLE, so that back-to-back frames are received.
REQ-025 p_data SHALL hold its value until the next DATA_VLD; errored frames SHALL NOT update p_data.
REQ-026 All outputs SHALL be registered; data_valid, par_err and stp_err are never high together.

Reset
REQ-027 rst SHALL force IDLE and clear edge_cnt, bit_cnt, the deserialiser and p_data to 0; data_valid, par_err, stp_err and busy are 0.
REQ-028 rst asserted mid-frame SHALL abort the frame with no valid or error pulse; reception resumes on the first low rx_in after rst is released.

Configuration
REQ-029 Macro UART_RX_BREAK_DET_EN SHALL add output brk_det (1 bit, reset 0).
REQ-030 With UART_RX_BREAK_DET_EN defined, a frame whose data, parity and stop bits all sample 0 SHALL pulse brk_det for one cycle instead of stp_err, and the FSM SHALL stay in IDLE until rx_in returns high.
REQ-031 Without UART_RX_BREAK_DET_EN, brk_det SHALL be absent and such a frame SHALL be reported as stp_err.

Structure
REQ-032 A shared package uart_pkg SHALL hold the state enum, the legal prescale constants (8/16/32) and the parity-type encoding.
REQ-033 The 3-sample majority voter with its sample-point decode SHALL be the sub-module uart_rx_sampler; the FSM, counters, deserialiser and parity logic stay in uart_rx_ctrl.

Verification
REQ-034 prescale = 8, no parity, 1 stop bit, frame 0xA5 -> p_data = 0xA5 and a single data_valid pulse.
REQ-035 prescale = 16, par_en = 1, par_typ = 0, frame 0x3C with a wrong parity bit -> par_err pulse, no data_valid, and p_data unchanged.
REQ-036 prescale = 32, stp2_en = 1, frame 0x81 with the second stop bit low -> stp_err pulse.
REQ-037 A start pulse low for 3 clocks at prescale = 16 -> return to IDLE with no outputs.
REQ-038 Two back-to-back frames 0x12 and 0x34 with no idle gap -> two data_valid pulses in order.
REQ-039 rst asserted at bit 4 of a frame, then a clean 0x55 frame -> only a single data_valid, with p_data = 0x55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
// Also defines the helper used to pick the bit value from three line samples.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ERR_CHK,
    ST_DATA_VLD
  } state_e;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Output bundle of the UART receiver: received word, status pulses and busy.
// brk_det exists only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] p_data;
  logic              data_valid;
  logic              par_err;
  logic              stp_err;
  logic              busy;
`ifdef UART_RX_BREAK_DET_EN
  logic              brk_det;

  modport master (output p_data, data_valid, par_err, stp_err, busy, brk_det);
  modport slave  (input  p_data, data_valid, par_err, stp_err, busy, brk_det);
`else
  modport master (output p_data, data_valid, par_err, stp_err, busy);
  modport slave  (input  p_data, data_valid, par_err, stp_err, busy);
`endif
endinterface

// File: rtl/uart_rx_sampler.sv
// Mid-bit 2-of-3 majority sampler; smp_vld is high for the one cycle after
// the voted bit is registered.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [PRESC_W-1:0] edge_cnt,
  output logic               smp_bit,
  output logic               smp_vld
);

  logic [PRESC_W-1:0] half;
  logic s0_q, s0_d, s1_q, s1_d, bit_q, bit_d, vld_q, vld_d;

  // Third sample is taken live so the vote is ready right after the window.
  always_comb begin
    half  = prescale >> 1;
    s0_d  = s0_q;
    s1_d  = s1_q;
    bit_d = bit_q;
    vld_d = 1'b0;
    if (edge_cnt == half - PRESC_W'(1)) s0_d = rx_in;
    if (edge_cnt == half)               s1_d = rx_in;
    if (edge_cnt == half + PRESC_W'(1)) begin
      bit_d = majority3(s0_q, s1_q, rx_in);
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
      bit_q <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      bit_q <= bit_d;
      vld_q <= vld_d;
    end
  end

  assign smp_bit = bit_q;
  assign smp_vld = vld_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver: FSM, bit/edge counters, deserialiser and parity.
// Optional break detection is enabled with UART_RX_BREAK_DET_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               par_typ,
  input  logic               stp2_en,
  uart_rx_ctrl_if.master     rx_if
);

  localparam int BIT_W = 4;

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d, presc_q, presc_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d, last_data, last_stop;
  logic [DATA_W-1:0]  shift_q, shift_d, p_data_q, p_data_d;
  logic par_en_q, par_en_d, par_typ_q, par_typ_d, stp2_en_q, stp2_en_d;
  logic par_bad_q, par_bad_d, stp_bad_q, stp_bad_d;
  logic data_valid_q, data_valid_d, par_err_q, par_err_d;
  logic stp_err_q, stp_err_d, busy_q, busy_d;
  logic counting, bit_end, smp_bit, smp_vld;
`ifdef UART_RX_BREAK_DET_EN
  logic nz_q, nz_d, brk_wait_q, brk_wait_d, brk_det_q, brk_det_d;
`endif

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .prescale (presc_q),
    .edge_cnt (edge_cnt_q),
    .smp_bit  (smp_bit),
    .smp_vld  (smp_vld)
  );

  // Bit index 0 is the start bit; data, parity and stop bits follow.
  assign last_data = BIT_W'(DATA_W);
  assign last_stop = BIT_W'(DATA_W + 1) + BIT_W'(par_en_q) + BIT_W'(stp2_en_q);

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = '0;
    bit_cnt_d    = '0;
    presc_d      = presc_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    stp2_en_d    = stp2_en_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    par_bad_d    = par_bad_q;
    stp_bad_d    = stp_bad_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    nz_d         = nz_q;
    brk_wait_d   = brk_wait_q;
    brk_det_d    = 1'b0;
`endif
    counting = state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    bit_end  = (edge_cnt_q == presc_q - PRESC_W'(1));

    if (counting) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESC_W'(1);
      bit_cnt_d  = bit_end ? bit_cnt_q + BIT_W'(1) : bit_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
`ifdef UART_RX_BREAK_DET_EN
        if (brk_wait_q) begin
          if (rx_in) brk_wait_d = 1'b0;
        end else
`endif
        if (!rx_in) state_d = ST_START;
      end
      ST_START: if (bit_end) state_d = smp_bit ? ST_IDLE : ST_DATA;
      ST_DATA: if (bit_end) begin
        shift_d = {smp_bit, shift_q[DATA_W-1:1]};
        if (bit_cnt_q == last_data) state_d = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end) begin
        par_bad_d = (smp_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD)));
`ifdef UART_RX_BREAK_DET_EN
        nz_d      = nz_q | smp_bit;
`endif
        state_d   = ST_STOP;
      end
      // Leave as soon as the last stop bit is voted so a following start bit is not missed.
      ST_STOP: if (smp_vld) begin
        stp_bad_d = stp_bad_q | ~smp_bit;
`ifdef UART_RX_BREAK_DET_EN
        nz_d      = nz_q | smp_bit;
`endif
        if (bit_cnt_q == last_stop) state_d = ST_ERR_CHK;
      end
      ST_ERR_CHK: begin
        state_d = ST_IDLE;
`ifdef UART_RX_BREAK_DET_EN
        if ((shift_q == '0) && !nz_q) begin
          brk_det_d  = 1'b1;
          brk_wait_d = 1'b1;
        end else
`endif
        if (stp_bad_q) begin
          stp_err_d = 1'b1;
        end else if (par_bad_q) begin
          par_err_d = 1'b1;
        end else begin
          data_valid_d = 1'b1;
          p_data_d     = shift_q;
          state_d      = ST_DATA_VLD;
        end
      end
      ST_DATA_VLD: state_d = rx_in ? ST_IDLE : ST_START;
      default: state_d = ST_IDLE;
    endcase

    // Configuration and per-frame flags are captured on every frame start.
    if (state_d == ST_START && !counting) begin
      presc_d   = prescale;
      par_en_d  = par_en;
      par_typ_d = par_typ;
      stp2_en_d = stp2_en;
      par_bad_d = 1'b0;
      stp_bad_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      nz_d      = 1'b0;
`endif
    end

    if (!(state_d inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      stp2_en_q    <= 1'b0;
      shift_q      <= '0;
      p_data_q     <= '0;
      par_bad_q    <= 1'b0;
      stp_bad_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      nz_q         <= 1'b0;
      brk_wait_q   <= 1'b0;
      brk_det_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      stp2_en_q    <= stp2_en_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      par_bad_q    <= par_bad_d;
      stp_bad_q    <= stp_bad_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_BREAK_DET_EN
      nz_q         <= nz_d;
      brk_wait_q   <= brk_wait_d;
      brk_det_q    <= brk_det_d;
`endif
    end
  end

  assign rx_if.p_data     = p_data_q;
  assign rx_if.data_valid = data_valid_q;
  assign rx_if.par_err    = par_err_q;
  assign rx_if.stp_err    = stp_err_q;
  assign rx_if.busy       = busy_q;
`ifdef UART_RX_BREAK_DET_EN
  assign rx_if.brk_det    = brk_det_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are serialised onto rx_in while a
// monitor pops the expected outcome each time the receiver reports something.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  typedef enum int {EV_VALID, EV_PERR, EV_SERR, EV_BRK} ev_e;
  typedef struct {
    ev_e           kind;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic [PW-1:0] prescale = PW'(PRESC_16);
  logic          par_en = 1'b0;
  logic          par_typ = PAR_EVEN;
  logic          stp2_en = 1'b0;

  int            compared = 0;
  int            mismatched = 0;
  exp_t          sb[$];
  logic [DW-1:0] last_good = '0;

  uart_rx_ctrl_if #(.DATA_W(DW)) rx_if ();

  uart_rx_ctrl #(.DATA_W(DW), .PRESC_W(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .prescale (prescale),
    .par_en   (par_en),
    .par_typ  (par_typ),
    .stp2_en  (stp2_en),
    .rx_if    (rx_if)
  );

  always #5 clk = ~clk;

  // Reference outcome of one frame, decided from the bits put on the line.
  function automatic ev_e modelEvent(input logic pe, input logic pt, input logic s2e,
                                     input logic [DW-1:0] data, input logic pbit,
                                     input logic s1, input logic s2);
    logic stop_ok;
    stop_ok = s1 && (!s2e || s2);
`ifdef UART_RX_BREAK_DET_EN
    if (data == '0 && (!pe || !pbit) && !s1 && (!s2e || !s2)) return EV_BRK;
`endif
    if (!stop_ok) return EV_SERR;
    if (pe && (pbit != ((^data) ^ (pt == PAR_ODD)))) return EV_PERR;
    return EV_VALID;
  endfunction

  function automatic int pickPresc();
    case ($urandom_range(0, 2))
      0:       return PRESC_8;
      1:       return PRESC_16;
      default: return PRESC_32;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one level for n clocks; always returns 1 time unit after a rising edge.
  task automatic holdBit(input logic b, input int n);
    if (n <= 0) return;
    rx_in = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input int p, input logic pe, input logic pt, input logic s2e,
                           input logic [DW-1:0] data, input logic pbit,
                           input logic s1, input logic s2, input int gap);
    exp_t e;
    prescale = PW'(p);
    par_en   = pe;
    par_typ  = pt;
    stp2_en  = s2e;
    e.kind   = modelEvent(pe, pt, s2e, data, pbit, s1, s2);
    e.data   = data;
    sb.push_back(e);
    holdBit(1'b0, p);
    prescale = PW'(pickPresc());
    par_en   = 1'($urandom);
    par_typ  = 1'($urandom);
    stp2_en  = 1'($urandom);
    for (int i = 0; i < DW; i++) holdBit(data[i], p);
    if (pe) holdBit(pbit, p);
    holdBit(s1, p);
    if (s2e) holdBit(s2, p);
    holdBit(1'b1, gap);
  endtask

  // err: 0 none, 1 wrong parity bit, 2 first stop low, 3 second stop low.
  task automatic applyStimulus(input int p, input logic pe, input logic pt, input logic s2e,
                               input logic [DW-1:0] data, input int err, input int gap);
    logic pbit;
    pbit = (^data) ^ (pt == PAR_ODD) ^ (err == 1);
    sendFrame(p, pe, pt, s2e, data, pbit, err != 2, err != 3, gap);
  endtask

  always @(negedge clk) begin
    int   n;
    ev_e  act;
    exp_t e;
    logic brk;
`ifdef UART_RX_BREAK_DET_EN
    brk = rx_if.brk_det;
`else
    brk = 1'b0;
`endif
    if (rst) begin
      last_good = '0;
    end else begin
      n = int'(rx_if.data_valid) + int'(rx_if.par_err) + int'(rx_if.stp_err) + int'(brk);
      if (n > 1) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL exclusive: %0d status pulses high together, required at most 1", n);
      end else if (n == 1) begin
        act = rx_if.data_valid ? EV_VALID : rx_if.par_err ? EV_PERR :
              rx_if.stp_err ? EV_SERR : EV_BRK;
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected: got %s pulse, required none", act.name());
        end else begin
          e = sb.pop_front();
          if (act != e.kind) begin
            mismatched++;
            $display("[TB] FAIL event: got %s, required %s", act.name(), e.kind.name());
          end
          compared++;
          if (e.kind == EV_VALID) begin
            if (rx_if.p_data !== e.data) begin
              mismatched++;
              $display("[TB] FAIL p_data: got %0h, required %0h", rx_if.p_data, e.data);
            end
            last_good = e.data;
          end else if (rx_if.p_data !== last_good) begin
            mismatched++;
            $display("[TB] FAIL p_data_held: got %0h, required %0h", rx_if.p_data, last_good);
          end
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    compared++;
    mismatched++;
    $display("[TB] FAIL watchdog: run still active, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int p, gap, err;
    logic pe, pt, s2e, stop_bad;
    logic [DW-1:0] d;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_p_data", 32'(rx_if.p_data), 0);
    checkOutput("reset_data_valid", 32'(rx_if.data_valid), 0);
    checkOutput("reset_par_err", 32'(rx_if.par_err), 0);
    checkOutput("reset_stp_err", 32'(rx_if.stp_err), 0);
    checkOutput("reset_busy", 32'(rx_if.busy), 0);
    rst = 1'b0;
    holdBit(1'b1, 4);

    $display("[TB] directed frames");
    applyStimulus(PRESC_8, 1'b0, PAR_EVEN, 1'b0, 8'hA5, 0, 20);
    applyStimulus(PRESC_16, 1'b1, PAR_EVEN, 1'b0, 8'h3C, 1, 20);
    applyStimulus(PRESC_32, 1'b0, PAR_EVEN, 1'b1, 8'h81, 3, 80);

    prescale = PW'(PRESC_16);
    holdBit(1'b0, 3);
    checkOutput("glitch_busy", 32'(rx_if.busy), 1);
    holdBit(1'b1, 40);
    checkOutput("glitch_idle", 32'(rx_if.busy), 0);

    applyStimulus(PRESC_16, 1'b0, PAR_EVEN, 1'b0, 8'h12, 0, 0);
    applyStimulus(PRESC_16, 1'b0, PAR_EVEN, 1'b0, 8'h34, 0, 20);

    d = 8'hF0;
    prescale = PW'(PRESC_16);
    par_en   = 1'b0;
    stp2_en  = 1'b0;
    holdBit(1'b0, 16);
    for (int i = 0; i < 4; i++) holdBit(d[i], 16);
    holdBit(d[4], 5);
    checkOutput("abort_busy", 32'(rx_if.busy), 1);
    rx_in = 1'b1;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_reset_busy", 32'(rx_if.busy), 0);
    checkOutput("abort_reset_p_data", 32'(rx_if.p_data), 0);
    rst = 1'b0;
    holdBit(1'b1, 10);
    applyStimulus(PRESC_16, 1'b0, PAR_EVEN, 1'b0, 8'h55, 0, 20);

    sendFrame(PRESC_16, 1'b0, PAR_EVEN, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 48);

    $display("[TB] randomized frames");
    for (int k = 0; k < 24; k++) begin
      p   = pickPresc();
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      s2e = 1'($urandom);
      d   = DW'($urandom);
      case ($urandom_range(0, 9))
        6, 7:    err = 1;
        8:       err = 2;
        9:       err = 3;
        default: err = 0;
      endcase
      stop_bad = (err == 2) || (err == 3 && s2e);
      if (stop_bad)      gap = 2 * p + int'($urandom_range(0, p));
      else if (p == 8)   gap = int'($urandom_range(1, p));
      else               gap = int'($urandom_range(0, p));
      applyStimulus(p, pe, pt, s2e, d, err, gap);
    end

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 0);
    holdBit(1'b1, 100);
    checkOutput("final_idle", 32'(rx_if.busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
